// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID slave generator and its checker.
// One source for the word map and the expected image identity.
package sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      LAT_ID,
      REQ_TS,
      LAT_TS,
      FIN
   } state_e;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_EXPECTED_ID        = 32'd11;
   localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1447922295;

endpackage

// File: rtl/avm_single_read.sv
// Single Avalon-MM read: holds the request through waitrequest, aborts after
// TIMEOUT_CYCLES stalls, and flags data READ_LATENCY cycles after acceptance.
module avm_single_read #(
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        go,
   input  logic        addr,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        avm_read,
   output logic        avm_address,
   output logic [31:0] rdata_out,
   output logic        valid,
   output logic        to
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  LAT_LOAD  = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic [15:0] wait_q, wait_d;
   logic [2:0]  lat_q, lat_d;
   logic        lat_busy_q, lat_busy_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         read_q     <= 1'b0;
         addr_q     <= 1'b0;
         wait_q     <= '0;
         lat_q      <= '0;
         lat_busy_q <= 1'b0;
      end else begin
         read_q     <= read_d;
         addr_q     <= addr_d;
         wait_q     <= wait_d;
         lat_q      <= lat_d;
         lat_busy_q <= lat_busy_d;
      end
   end

   always_comb begin
      read_d     = read_q;
      addr_d     = addr_q;
      wait_d     = wait_q;
      lat_d      = lat_q;
      lat_busy_d = lat_busy_q;
      valid      = 1'b0;
      to         = 1'b0;
      if (go) begin
         read_d = 1'b1;
         addr_d = addr;
         wait_d = '0;
      end else if (read_q) begin
         if (avm_waitrequest) begin
            if (wait_q == WAIT_LAST) begin
               to     = 1'b1;
               read_d = 1'b0;
               wait_d = '0;
            end else if (wait_q != '1) begin
               wait_d = wait_q + 16'd1;
            end
         end else begin
            read_d = 1'b0;
            wait_d = '0;
            // zero latency: data is sampled in the acceptance cycle itself
            if (READ_LATENCY == 0) begin
               valid = 1'b1;
            end else begin
               lat_busy_d = 1'b1;
               lat_d      = LAT_LOAD;
            end
         end
      end else if (lat_busy_q) begin
         if (lat_q == '0) begin
            valid      = 1'b1;
            lat_busy_d = 1'b0;
         end else begin
            lat_d = lat_q - 3'd1;
         end
      end
   end

   assign avm_read    = read_q;
   assign avm_address = addr_q;
   assign rdata_out   = avm_readdata;

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and timestamp words once per check and compares them
// against the build constants, reporting pass/fail/timeout flags.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter logic        AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout
);

   state_e      state_q, state_d;
   logic        first_q, first_d;
   logic        launch_q, launch_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;

   logic        rd_go, rd_addr, rd_valid, rd_to, accept;
   logic [31:0] rd_data;

   avm_single_read #(
      .READ_LATENCY   (READ_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read (
      .clock           (clock),
      .reset           (reset),
      .go              (rd_go),
      .addr            (rd_addr),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .avm_read        (avm_read),
      .avm_address     (avm_address),
      .rdata_out       (rd_data),
      .valid           (rd_valid),
      .to              (rd_to)
   );

   assign accept = avm_read & ~avm_waitrequest;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         first_q   <= AUTO_START;
         launch_q  <= 1'b0;
         id_q      <= '0;
         ts_q      <= '0;
         id_ok_q   <= 1'b0;
         ts_ok_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         launch_q  <= launch_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         id_ok_q   <= id_ok_d;
         ts_ok_q   <= ts_ok_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      first_d   = 1'b0;
      launch_d  = 1'b0;
      id_d      = id_q;
      ts_d      = ts_q;
      id_ok_d   = id_ok_q;
      ts_ok_d   = ts_ok_q;
      timeout_d = timeout_q;
      rd_go     = 1'b0;
      rd_addr   = SYSID_ADDR_ID;
      case (state_q)
         IDLE: begin
            if (start || first_q) begin
               rd_go     = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
               state_d   = REQ_ID;
            end
         end
         REQ_ID, LAT_ID: begin
            if (rd_to) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end else if (rd_valid) begin
               id_d     = rd_data;
               id_ok_d  = (rd_data == EXPECTED_ID);
               launch_d = 1'b1;
               state_d  = REQ_TS;
            end else if (accept) begin
               state_d = LAT_ID;
            end
         end
         REQ_TS, LAT_TS: begin
            // the TS read is launched one cycle late to leave an idle gap
            rd_addr = SYSID_ADDR_TS;
            rd_go   = launch_q;
            if (rd_to) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end else if (rd_valid) begin
               ts_d    = rd_data;
               ts_ok_d = (rd_data == EXPECTED_TIMESTAMP);
               state_d = FIN;
            end else if (accept) begin
               state_d = LAT_TS;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign id_value        = id_q;
   assign timestamp_value = ts_q;
   assign id_ok           = id_ok_q;
   assign ts_ok           = ts_ok_q;
   assign timeout         = timeout_q;
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == FIN);

endmodule
